muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle unsigned multiply/divide unit that owns the architectural HI/LO registers for the execute stage.
- Accepts MULT/DIV requests from execute and iterates radix-2 (shift-add multiply, restoring divide) for 32 cycles.
- Drives a stall to the pipeline when MULT/DIV/MFHI/MFLO arrives while busy.
- The execute stage reads hi/lo outputs for MFHI/MFLO instead of keeping its own copies.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage holds a valid instruction this cycle
- req_aluop  in  6  aluop of that instruction (shared aluop encoding)
- op_a  in  WIDTH  bypassed rs value (multiplicand / dividend)
- op_b  in  WIDTH  bypassed rt value (multiplier / divisor)
- flush  in  1  squash in-flight operation (branch/jump kill)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  iteration in progress
- stall  out  1  hold execute and earlier stages this cycle
- done  out  1  one-cycle pulse when HI/LO were written by a completed operation

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. stall is combinational, so it is 0 after reset. Reset mid-operation aborts with no HI/LO write.
- States: IDLE, MUL, DIV.
- Start: in IDLE, a rising edge with req_valid=1, flush=0 and req_aluop=MULT_OP (6'b000010) or DIV_OP (6'b000011) captures op_a/op_b and counter=0. State goes to MUL or DIV, except that DIV with op_b=0 goes to the divide-by-zero path. This is edge E0.
- Any other aluop in IDLE does nothing.
- MUL: one shift-add step per edge E1..E32 on a 2*WIDTH product register. At E32: {hi,lo} = op_a*op_b as a full 64-bit unsigned product, state→IDLE, done=1 for exactly the following cycle.
- DIV: one restoring step per edge E1..E32. At E32: lo=quotient, hi=remainder (both unsigned), state→IDLE, done pulse.
- Divide by zero: at E0 go directly to a 1-cycle completion. At E1: lo=all ones, hi=op_a, done pulse, busy high only between E0 and E1.
- busy=1 from after E0 through E32 (32 cycles for normal ops), 0 otherwise. done and busy are never high in the same cycle.
- stall = busy & req_valid & (req_aluop ∈ {MULT_OP, DIV_OP, MFHI_OP, MFLO_OP}); purely combinational, no registered delay.
- In the cycle after E32, busy=0, so a waiting MFHI/MFLO proceeds and sees the new hi/lo. A waiting MULT/DIV is accepted as a new start at that edge.
- Start while busy is never accepted; it is held off by stall.
- flush=1 while busy: at the next edge state→IDLE, busy=0, no done, hi/lo unchanged.
- flush=1 in IDLE blocks a start at that edge.
- flush and the completing edge E32 coincide: completion wins, because the instruction already passed execute. HI/LO are written and done pulses.
- Operands are latched at E0; later changes to op_a/op_b are ignored.
- Arithmetic is unsigned only, matching the existing ALU. No overflow signalling.

Decomposition:
- Shared package holds the aluop constants: MULT_OP, DIV_OP, MFHI_OP, MFLO_OP, plus the full aluop list already used by decode/execute, and WIDTH.
- State encoding is local to this block.
- One natural sub-module, muldiv_step: combinational single iteration that selects a shift-add or restoring-subtract step on the {remainder/product, quotient/multiplier} pair. The FSM and counter stay in muldiv_sequencer.

Test Plan:
- MULT 7×6 from reset → busy 32 cycles, then done pulse; lo=32'd42, hi=0; stall=0 throughout when req_valid=0.
- MULT 32'hFFFFFFFF×32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001 after E32.
- DIV 100/7 → lo=14, hi=2. DIV 5/0 → done at E1, lo=32'hFFFFFFFF, hi=5, busy high exactly one cycle.
- MULT 3×5 then MFLO presented with req_valid=1 from E1 → stall=1 for cycles E1..E32, drops to 0 in the cycle after E32; lo=15 is visible that cycle.
- DIV 1000/3, flush at E10 → busy=0 after E10, no done; hi/lo keep their prior values. Separately, flush at E32 → result written anyway.
- reset_n asserted asynchronously mid-MULT at cycle 15 → hi=lo=0, busy=0 immediately. After release, a new DIV 9/2 gives lo=4, hi=1.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared execute-stage definitions: operand width and the aluop encoding
// used by decode/execute, plus small helpers for classifying aluops.
package muldiv_sequencer_pkg;

  localparam int WIDTH   = 32;
  localparam int ALUOP_W = 6;

  typedef logic [ALUOP_W-1:0] aluop_t;

  // Full aluop list shared by decode and execute.
  localparam aluop_t NOP_OP  = 6'b000000;
  localparam aluop_t ADD_OP  = 6'b000001;
  localparam aluop_t MULT_OP = 6'b000010;
  localparam aluop_t DIV_OP  = 6'b000011;
  localparam aluop_t MFHI_OP = 6'b000100;
  localparam aluop_t MFLO_OP = 6'b000101;
  localparam aluop_t SUB_OP  = 6'b000110;
  localparam aluop_t AND_OP  = 6'b000111;
  localparam aluop_t OR_OP   = 6'b001000;
  localparam aluop_t XOR_OP  = 6'b001001;
  localparam aluop_t NOR_OP  = 6'b001010;
  localparam aluop_t SLT_OP  = 6'b001011;
  localparam aluop_t SLL_OP  = 6'b001100;
  localparam aluop_t SRL_OP  = 6'b001101;
  localparam aluop_t SRA_OP  = 6'b001110;
  localparam aluop_t LUI_OP  = 6'b001111;

  // True for aluops that launch a multi-cycle HI/LO operation.
  function automatic logic is_start_op(input aluop_t op);
    return (op == MULT_OP) || (op == DIV_OP);
  endfunction

  // True for aluops that must wait while HI/LO are being produced.
  function automatic logic uses_hilo(input aluop_t op);
    return (op == MULT_OP) || (op == DIV_OP) || (op == MFHI_OP) || (op == MFLO_OP);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc, q} register pair.
// Multiply: shift-add, acc holds the upper product half, q the multiplier.
// Divide: restoring step, acc holds the partial remainder, q the dividend
// being shifted out while quotient bits are shifted in.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);
  import muldiv_sequencer_pkg::*;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;

  // Select shift-add or restoring-subtract for this iteration.
  always_comb begin
    sum_s     = {1'b0, acc} + (q[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    shifted_s = {acc, q[WIDTH-1]};
    // Only used when shifted_s >= b, so the result always fits WIDTH bits.
    diff_s    = shifted_s[WIDTH-1:0] - b;
    if (is_div) begin
      if (shifted_s >= {1'b0, b}) begin
        acc_next = diff_s;
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted_s[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = sum_s[WIDTH:1];
      q_next   = {sum_s[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULT/DIV unit owning the architectural HI/LO registers.
// A start captures operands, then 32 radix-2 iterations produce the result;
// divide by zero completes one cycle after the start.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [5:0]       req_aluop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);
  import muldiv_sequencer_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DIVZ = 2'd3
  } state_e;

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r, q_r, b_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r;

  logic             start_s, last_s;
  logic             load_s, step_s, finish_s, finish_dz_s;
  logic [WIDTH-1:0] acc_next_s, q_next_s;

  assign start_s = req_valid & ~flush & is_start_op(req_aluop);
  assign last_s  = (cnt_r == CNT_W'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (state_r == ST_DIV),
    .acc      (acc_r),
    .q        (q_r),
    .b        (b_r),
    .acc_next (acc_next_s),
    .q_next   (q_next_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and datapath controls; completion takes priority over flush.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    finish_dz_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          load_s = 1'b1;
          if (req_aluop == MULT_OP) begin
            state_nxt_s = ST_MUL;
          end else if (op_b == {WIDTH{1'b0}}) begin
            state_nxt_s = ST_DIVZ;
          end else begin
            state_nxt_s = ST_DIV;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_s) begin
          step_s      = 1'b1;
          finish_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (flush) begin
          state_nxt_s = ST_IDLE;
        end else begin
          step_s      = 1'b1;
          state_nxt_s = state_r;
        end
      end
      ST_DIVZ: begin
        finish_dz_s = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture, iteration registers, counter and HI/LO write-back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      acc_r  <= {WIDTH{1'b0}};
      q_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      done_r <= 1'b0;
    end else begin
      done_r <= finish_s | finish_dz_s;
      if (load_s) begin
        cnt_r <= {CNT_W{1'b0}};
        acc_r <= {WIDTH{1'b0}};
        // Divide shifts the dividend out of q; multiply shifts the multiplier.
        q_r   <= (req_aluop == MULT_OP) ? op_b : op_a;
        b_r   <= (req_aluop == MULT_OP) ? op_a : op_b;
      end else if (step_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        acc_r <= acc_next_s;
        q_r   <= q_next_s;
      end
      if (finish_s) begin
        hi_r <= acc_next_s;
        lo_r <= q_next_s;
      end else if (finish_dz_s) begin
        hi_r <= q_r;
        lo_r <= {WIDTH{1'b1}};
      end
    end
  end

  assign hi    = hi_r;
  assign lo    = lo_r;
  assign done  = done_r;
  assign busy  = (state_r != ST_IDLE);
  assign stall = busy & req_valid & uses_hilo(req_aluop);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected {hi,lo}
// results, a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic [5:0]        req_aluop;
  logic [WIDTH-1:0]  op_a, op_b;
  logic              flush;
  logic [WIDTH-1:0]  hi, lo;
  logic              busy, stall, done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [WIDTH-1:0] model_hi = 32'd0;
  logic [WIDTH-1:0] model_lo = 32'd0;

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_aluop (req_aluop),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    if (op == MULT_OP) begin
      p = {32'd0, a} * {32'd0, b};
      return p;
    end else if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end else begin
      return {a % b, a / b};
    end
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clock) begin
    logic [63:0] e;
    if (reset_n && done) begin
      check("done_busy_exclusive", {63'd0, busy}, 64'd0);
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_hi_lo", {hi, lo}, e);
        model_hi = e[63:32];
        model_lo = e[31:0];
      end
    end
  end

  // Present a start for one edge (E0); afterwards scramble operands.
  task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_aluop = op; op_a = a; op_b = b;
    @(posedge clock); #1;
    req_valid = 1'b0; op_a = $urandom; op_b = $urandom;
  endtask

  // Full operation with busy-length, done-pulse and idle-stall checks.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int bc;
    int sb;
    exp_q.push_back(ref_result(op, a, b));
    start_op(op, a, b);
    bc = 0; sb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy) break;
      bc++;
      if (stall) sb++;
    end
    check("busy_cycles", 64'(bc), (op == DIV_OP && b == 32'd0) ? 64'd1 : 64'd32);
    check("done_pulse", {63'd0, done}, 64'd1);
    check("stall_without_req", 64'(sb), 64'd0);
    @(negedge clock);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int bad;
    int bc;
    int snap;
    logic [31:0] a, b;
    logic [5:0]  op;

    reset_n = 1'b0; req_valid = 1'b0; req_aluop = NOP_OP;
    op_a = 32'd0; op_b = 32'd0; flush = 1'b0;
    repeat (2) @(posedge clock); #1;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed results.
    run_op(MULT_OP, 32'd7, 32'd6);
    check("mult_7x6_lo", {32'd0, lo}, 64'd42);
    run_op(MULT_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mult_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(DIV_OP, 32'd100, 32'd7);
    check("div_100_7", {hi, lo}, {32'd2, 32'd14});
    run_op(DIV_OP, 32'd5, 32'd0);
    check("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

    // Non-start aluop in IDLE does nothing.
    req_valid = 1'b1; req_aluop = MFHI_OP;
    @(posedge clock); #1;
    check("idle_mfhi_no_start", {63'd0, busy}, 64'd0);
    req_valid = 1'b0;

    // MULT 3x5 with MFLO waiting from E1: stall through E32, then lo visible.
    exp_q.push_back(ref_result(MULT_OP, 32'd3, 32'd5));
    start_op(MULT_OP, 32'd3, 32'd5);
    req_valid = 1'b1; req_aluop = MFLO_OP;
    bad = 0; bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy) break;
      bc++;
      if (!stall) bad++;
    end
    check("mflo_busy_cycles", 64'(bc), 64'd32);
    check("mflo_stall_while_busy", 64'(bad), 64'd0);
    check("mflo_stall_released", {63'd0, stall}, 64'd0);
    check("mflo_sees_lo", {32'd0, lo}, 64'd15);
    req_valid = 1'b0;
    @(posedge clock); #1;

    // Flush at E10 kills DIV 1000/3 with no write.
    snap = done_cnt;
    start_op(DIV_OP, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    check("flush_busy_low", {63'd0, busy}, 64'd0);
    repeat (4) @(negedge clock);
    check("flush_no_done", 64'(done_cnt - snap), 64'd0);
    check("flush_hi_lo_kept", {hi, lo}, {model_hi, model_lo});
    @(posedge clock); #1;

    // Flush coinciding with E32: completion wins.
    exp_q.push_back(ref_result(DIV_OP, 32'd1000, 32'd3));
    start_op(DIV_OP, 32'd1000, 32'd3);
    repeat (31) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    check("flush_e32_done", {63'd0, done}, 64'd1);
    check("flush_e32_result", {hi, lo}, {32'd1, 32'd333});
    @(posedge clock); #1;

    // Asynchronous reset mid-MULT.
    start_op(MULT_OP, 32'd12345, 32'd678);
    repeat (14) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_hi_lo", {hi, lo}, 64'd0);
    check("async_reset_busy", {63'd0, busy}, 64'd0);
    model_hi = 32'd0; model_lo = 32'd0;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    run_op(DIV_OP, 32'd9, 32'd2);
    check("div_9_2", {hi, lo}, {32'd1, 32'd4});

    // Randomized mix against the reference model.
    for (int n = 0; n < 24; n++) begin
      op = ($urandom_range(0, 1) == 0) ? MULT_OP : DIV_OP;
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      run_op(op, a, b);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
